// File: rtl/mdr_hs.sv
// mdr_hs -- memory data register with a req/ack handshake to DRAM.
//
// Holds the word presented on the B bus and the word sent to DRAM. A read or
// write command starts a DRAM access (mem_req held high until mem_ack). The
// access ends when mem_ack arrives or when the wait budget runs out.
// busy, done, timeout and cmd_err report access status.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no access outstanding, commands accepted
// RD    | DRAM read requested, waiting for mem_ack
// WR    | DRAM write requested, waiting for mem_ack
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   load            capture c_bus into data_out_bbus (any state)
//   read, write     start a DRAM read / write of c_bus (IDLE only)
//   c_bus           C-bus data in
//   data_in_dram    DRAM read data, valid with mem_ack
//   mem_ack         DRAM access complete
//   data_out_bbus   register value to B bus
//   data_out_dram   write data to DRAM, held for the whole write
//   mem_req/mem_we  DRAM request and direction (1 = write)
//   busy            access in progress
//   done            1-cycle pulse: access completed with ack
//   timeout         1-cycle pulse: access aborted, no ack
//   cmd_err         1-cycle pulse: a command was dropped
module mdr_hs #(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] c_bus,
  input  logic [DATA_W-1:0] data_in_dram,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] data_out_bbus,
  output logic [DATA_W-1:0] data_out_dram,
  output logic              mem_req,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              cmd_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  // Last wait cycle index; the abort happens on the edge that sees this value.
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] bbus_q, bbus_d;
  logic [DATA_W-1:0] dram_q, dram_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              to_q, to_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bbus_q  <= '0;
      dram_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bbus_q  <= bbus_d;
      dram_q  <= dram_d;
      req_q   <= req_d;
      we_q    <= we_d;
      done_q  <= done_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bbus_d  = bbus_q;
    dram_d  = dram_q;
    req_d   = req_q;
    we_d    = we_q;
    done_d  = 1'b0;
    to_d    = 1'b0;
    err_d   = 1'b0;

    // Load is independent of the FSM; a read completion below overrides it.
    if (load) bbus_d = c_bus;

    case (state_q)
      S_IDLE: begin
        if (read) begin
          state_d = S_RD;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = 1'b0;
          err_d   = write;
        end else if (write) begin
          state_d = S_WR;
          cnt_d   = '0;
          dram_d  = c_bus;
          req_d   = 1'b1;
          we_d    = 1'b1;
        end
      end
      S_RD, S_WR: begin
        err_d = read | write;
        if (mem_ack) begin
          if (state_q == S_RD) bbus_d = data_in_dram;
          state_d = S_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          to_d    = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  assign data_out_bbus = bbus_q;
  assign data_out_dram = dram_q;
  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign timeout       = to_q;
  assign cmd_err       = err_q;

endmodule

// File: tb/tb_mdr_hs.sv
module tb_mdr_hs;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0, read = 1'b0, write = 1'b0, mem_ack = 1'b0;
  logic [7:0] c_bus = 8'h00, data_in_dram = 8'h00;
  logic [7:0] data_out_bbus, data_out_dram;
  logic       mem_req, mem_we, busy, done, timeout, cmd_err;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  mdr_hs #(.DATA_W(8), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .read(read), .write(write),
    .c_bus(c_bus), .data_in_dram(data_in_dram), .mem_ack(mem_ack),
    .data_out_bbus(data_out_bbus), .data_out_dram(data_out_dram),
    .mem_req(mem_req), .mem_we(mem_we), .busy(busy), .done(done),
    .timeout(timeout), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: an access is "outstanding" from the command until ack
  // or until TO cycles have gone by without ack.
  logic       m_act = 0, m_wr = 0;
  int         m_waits = 0;
  logic [7:0] m_bbus = 0, m_dram = 0;
  logic       m_req = 0, m_we = 0, m_done = 0, m_to = 0, m_err = 0;

  always @(posedge clk or negedge rst_n) begin : model
    logic       act, wr, rq, we, dn, tout, er;
    int         w;
    logic [7:0] bb, dr;
    if (!rst_n) begin
      m_act <= 0; m_wr <= 0; m_waits <= 0; m_bbus <= 0; m_dram <= 0;
      m_req <= 0; m_we <= 0; m_done <= 0; m_to <= 0; m_err <= 0;
    end else begin
      act = m_act; wr = m_wr; w = m_waits; bb = m_bbus; dr = m_dram;
      rq = m_req; we = m_we; dn = 0; tout = 0; er = 0;
      if (load) bb = c_bus;
      if (!act) begin
        if (read) begin
          act = 1; wr = 0; w = 0; rq = 1; we = 0; er = write;
        end else if (write) begin
          act = 1; wr = 1; w = 0; rq = 1; we = 1; dr = c_bus;
        end
      end else begin
        er = read | write;
        if (mem_ack) begin
          if (!wr) bb = data_in_dram;
          act = 0; rq = 0; we = 0; dn = 1;
        end else begin
          w = w + 1;
          if (w == TO) begin
            act = 0; rq = 0; we = 0; tout = 1;
          end
        end
      end
      m_act <= act; m_wr <= wr; m_waits <= w; m_bbus <= bb; m_dram <= dr;
      m_req <= rq; m_we <= we; m_done <= dn; m_to <= tout; m_err <= er;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_bbus",   data_out_bbus, m_bbus);
      chk("m_dram",   data_out_dram, m_dram);
      chk("m_req",    8'(mem_req),   8'(m_req));
      chk("m_we",     8'(mem_we),    8'(m_we));
      chk("m_busy",   8'(busy),      8'(m_act));
      chk("m_done",   8'(done),      8'(m_done));
      chk("m_tout",   8'(timeout),   8'(m_to));
      chk("m_cmderr", 8'(cmd_err),   8'(m_err));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    check_en = 1'b1;
    tick();
    chk("rst_bbus", data_out_bbus, 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);

    // 1: reset mid-read drops everything immediately
    read = 1; tick(); read = 0;
    tick();
    chk("t1_req_before", 8'(mem_req), 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_req_async",  8'(mem_req), 8'h00);
    chk("t1_busy_async", 8'(busy), 8'h00);
    chk("t1_dram_async", data_out_dram, 8'h00);
    tick(); rst_n = 1'b1;
    tick();
    chk("t1_idle", 8'(busy), 8'h00);

    // 2: read with 3 wait states
    read = 1; data_in_dram = 8'hA5; tick(); read = 0;
    chk("t2_busy", 8'(busy), 8'h01);
    chk("t2_we", 8'(mem_we), 8'h00);
    tick(); tick(); tick();
    chk("t2_busy_wait", 8'(busy), 8'h01);
    mem_ack = 1; tick(); mem_ack = 0;
    chk("t2_bbus", data_out_bbus, 8'hA5);
    chk("t2_done", 8'(done), 8'h01);
    chk("t2_req", 8'(mem_req), 8'h00);
    tick();
    chk("t2_done_1cyc", 8'(done), 8'h00);

    // 3: write data held while c_bus changes
    c_bus = 8'h3C; write = 1; tick(); write = 0; c_bus = 8'hFF;
    chk("t3_we", 8'(mem_we), 8'h01);
    tick(); tick();
    chk("t3_dram_hold", data_out_dram, 8'h3C);
    mem_ack = 1; tick(); mem_ack = 0;
    chk("t3_done", 8'(done), 8'h01);
    chk("t3_we_off", 8'(mem_we), 8'h00);
    chk("t3_dram_end", data_out_dram, 8'h3C);

    // 4: timeout after 4 cycles in RD, then ack on the 4th cycle
    load = 1; c_bus = 8'h11; tick(); load = 0;
    read = 1; tick(); read = 0;
    tick(); tick(); tick();
    chk("t4_no_to_yet", 8'(timeout), 8'h00);
    tick();
    chk("t4_timeout", 8'(timeout), 8'h01);
    chk("t4_req", 8'(mem_req), 8'h00);
    chk("t4_bbus", data_out_bbus, 8'h11);
    tick();
    chk("t4_to_1cyc", 8'(timeout), 8'h00);
    read = 1; data_in_dram = 8'h33; tick(); read = 0;
    tick(); tick(); tick();
    mem_ack = 1; tick(); mem_ack = 0;
    chk("t4_ack_done", 8'(done), 8'h01);
    chk("t4_ack_no_to", 8'(timeout), 8'h00);
    chk("t4_ack_bbus", data_out_bbus, 8'h33);

    // 5: conflicts
    read = 1; write = 1; tick(); read = 0;
    chk("t5_rw_err", 8'(cmd_err), 8'h01);
    chk("t5_rw_rd", 8'(mem_we), 8'h00);
    tick(); write = 0;
    chk("t5_wr_in_rd_err", 8'(cmd_err), 8'h01);
    chk("t5_wr_in_rd_we", 8'(mem_we), 8'h00);
    tick();
    chk("t5_err_1cyc", 8'(cmd_err), 8'h00);
    load = 1; c_bus = 8'h77; mem_ack = 1; data_in_dram = 8'h22; tick();
    load = 0; mem_ack = 0;
    chk("t5_dram_wins", data_out_bbus, 8'h22);

    // 6: plain load and stray ack
    load = 1; c_bus = 8'h5A; tick(); load = 0;
    chk("t6_load", data_out_bbus, 8'h5A);
    mem_ack = 1; data_in_dram = 8'hC3; tick(); mem_ack = 0;
    chk("t6_stray_done", 8'(done), 8'h00);
    chk("t6_stray_bbus", data_out_bbus, 8'h5A);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      read         = ($urandom_range(0, 7) == 0);
      write        = ($urandom_range(0, 7) == 0);
      load         = ($urandom_range(0, 5) == 0);
      mem_ack      = ($urandom_range(0, 4) == 0);
      c_bus        = 8'($urandom);
      data_in_dram = 8'($urandom);
      tick();
    end
    read = 0; write = 0; load = 0; mem_ack = 0;
    tick();
    check_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
